fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core. It sits between the PC logic and a synchronous-read instruction memory (block RAM or BIOS), and replaces the single-register fetch stage. It keeps up to DEPTH instruction requests outstanding or buffered, and hands instructions to decode over a valid/ready handshake. It flushes cleanly on branch/jump redirects and adds backpressure that the single-register fetch stage does not support.

---
 rtl/riscv_fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants for the RISC-V instruction-fetch front end.
//   INST_W   : instruction width in bits
//   PC_STEP  : byte distance between consecutive sequential fetches
//   NOP_INST : addi x0,x0,0; decode substitutes this when out_valid=0
package riscv_fetch_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that buffers {inst, pc} entries between the instruction
// memory response and decode. The head is read combinationally, with no
// bypass, so a pushed entry becomes visible the cycle after the push.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop every entry (takes priority over push/pop)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry
//   head_data  : entry at the head (don't-care when count == 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every
  // read, so stale contents are never observed and the array maps to RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches to a
// synchronous-read instruction memory, buffers responses in a small FIFO,
// and hands them to decode over valid/ready. A redirect flushes all
// buffered and in-flight work and restarts fetch at the new target.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_re         : fetch request this cycle
//   imem_addr       : word-aligned byte address of the request (= fetch_pc)
//   imem_rdata      : instruction for the request issued the previous cycle
//   redirect_valid  : taken branch/jump; flush and refetch
//   redirect_pc     : redirect target, bits [1:0] ignored
//   out_valid       : out_inst/out_pc hold a valid instruction
//   out_ready       : decode accepts the head instruction
//   out_inst        : instruction at the queue head
//   out_pc          : address of out_inst
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            DEPTH    = 4,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_re,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INST_W-1:0]   imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic [ADDR_W-1:0]   out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = INST_W + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q,   req_pc_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head_data;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  // A redirect flushes the FIFO anyway, so a pop in that cycle is ignored.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = inflight_q && !redirect_valid;

  // Slots committed after this cycle: buffered + arriving - leaving. Issuing
  // only while this is below DEPTH guarantees the FIFO never overflows,
  // while still sustaining one fetch per cycle when decode keeps up.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = !rst && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end
    if (issue) req_pc_d = fetch_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, req_pc_q}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign imem_re   = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count != '0);
  assign out_inst  = head_data[ENT_W-1:ADDR_W];
  assign out_pc    = head_data[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (ADDR_W=14 to exercise PC wrap).
// A scoreboard holds the architectural instruction stream expected after
// the last reset/redirect; a negedge monitor pops it on every handshake.
// Directed latency checks and a randomized phase drive the stimulus.
module tb_fetch_queue;

  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_re;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q [$];

  fetch_queue #(
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_re        (imem_re),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] inst_of(input logic [AW-1:0] pc);
    return {pc, 18'h0} ^ 32'h1357_9BDF ^ {18'h0, pc};
  endfunction

  // Synchronous-read memory; garbage when not read, to expose stray pushes.
  always @(posedge clk)
    imem_rdata <= imem_re ? inst_of(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after a restart at target T the accepted stream is
  // T, T+4, T+8, ... modulo 2^AW, independent of backpressure.
  task automatic model_restart(input logic [AW-1:0] target);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(target + AW'(4 * i));
  endtask

  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got pc 0x%04h expected nothing at %0t", out_pc, $time);
      end else begin
        logic [AW-1:0] pc;
        pc = exp_q.pop_front();
        check("out_pc", 32'(out_pc), 32'(pc));
        check("out_inst", out_inst, inst_of(pc));
        if (exp_q.size() == 0) exp_q.push_back(pc + AW'(4));
        else                   exp_q.push_back(exp_q[$] + AW'(4));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset for one cycle; ends at the start of the first post-reset cycle.
  task automatic do_reset(input logic with_redirect);
    rst            = 1'b1;
    redirect_valid = with_redirect;
    redirect_pc    = 14'h0200;
    exp_q.delete();
    @(negedge clk);
    check("rst_imem_re", 32'(imem_re), 32'd0);
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    model_restart(RESET_PC);
  endtask

  // Cold-start latency: issue in R, data in R+1, out_valid in R+2.
  task automatic cold_checks;
    @(negedge clk);
    check("cold_valid_r0", 32'(out_valid), 32'd0);
    check("cold_re_r0", 32'(imem_re), 32'd1);
    check("cold_addr_r0", 32'(imem_addr), 32'(RESET_PC));
    tick();
    @(negedge clk);
    check("cold_valid_r1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("cold_valid_r2", 32'(out_valid), 32'd1);
    check("cold_pc_r2", 32'(out_pc), 32'(RESET_PC));
    tick();
  endtask

  task automatic do_redirect(input logic [AW-1:0] target);
    logic [AW-1:0] aligned;
    aligned        = target & ~AW'(3);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_q.delete();
    @(negedge clk);
    check("redir_re_n", 32'(imem_re), 32'd0);
    tick();
    redirect_valid = 1'b0;
    model_restart(aligned);
    @(negedge clk);
    check("redir_valid_n1", 32'(out_valid), 32'd0);
    check("redir_re_n1", 32'(imem_re), 32'd1);
    check("redir_addr_n1", 32'(imem_addr), 32'(aligned));
    tick();
    @(negedge clk);
    check("redir_valid_n2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_valid_n3", 32'(out_valid), 32'd1);
    check("redir_pc_n3", 32'(out_pc), 32'(aligned));
    tick();
  endtask

  task automatic expect_no_bubbles(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, 32'(out_valid), 32'd1);
      tick();
    end
  endtask

  initial begin
    int n_req;
    logic [AW-1:0] last_addr;

    tick();
    tick();

    // Cold start with full throughput.
    out_ready = 1'b1;
    do_reset(1'b0);
    cold_checks();
    expect_no_bubbles("stream_valid", 16);

    // Backpressure from reset: exactly DEPTH requests, head held.
    out_ready = 1'b0;
    do_reset(1'b0);
    n_req     = 0;
    last_addr = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_re) begin
        n_req++;
        last_addr = imem_addr;
      end
      if (i >= 3) check("bp_head_pc", 32'(out_pc), 32'h0);
      tick();
    end
    @(negedge clk);
    check("bp_req_count", 32'(n_req), 32'(DEPTH));
    check("bp_last_addr", 32'(last_addr), 32'h000C);
    check("bp_re_idle", 32'(imem_re), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_re", 32'(imem_re), 32'd1);
    check("bp_release_addr", 32'(imem_addr), 32'h0010);
    tick();
    expect_no_bubbles("drain_valid", 10);

    // Redirects mid-stream: aligned, misaligned, and wrapping.
    do_redirect(14'h0100);
    expect_no_bubbles("post_redir_valid", 6);
    do_redirect(14'h0102);
    expect_no_bubbles("post_misalign_valid", 4);
    do_redirect(14'h3FF8);
    expect_no_bubbles("wrap_valid", 6);

    // Redirect coincident with reset: reset wins.
    do_reset(1'b1);
    cold_checks();
    expect_no_bubbles("rst_redir_valid", 4);

    // Reset with three entries buffered and one request in flight.
    out_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    do_reset(1'b0);
    cold_checks();
    expect_no_bubbles("restart_valid", 8);

    // Randomized backpressure, redirects and resets.
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
        cold_checks();
      end else if ($urandom_range(0, 19) == 0) begin
        do_redirect(AW'($urandom_range(0, 16383)));
      end else begin
        tick();
      end
    end

    // Let the final state settle with decode always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
